// File: rtl/mem_access_ctrl.sv
// M-stage memory access sequencer: drives loads/stores onto a handshaked data bus,
// checks alignment, times out stalled transfers and survives flushes mid-transaction.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        exc_bus,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_byteen,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  ext_byteen,
  output logic        ext_op,
  output logic [31:0] ext_din,
  input  logic [31:0] ext_dout
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP, S_DRAIN} state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       exc_q, exc_d;   // {bus, ades, adel}

  logic       is_load;
  logic       timeout;
  logic [3:0] byteen;

  function automatic logic [3:0] lane_en(input logic [2:0] op, input logic [1:0] a);
    case (op)
      3'd0, 3'd5:       lane_en = 4'b1111;
      3'd1, 3'd2, 3'd6: lane_en = a[1] ? 4'b1100 : 4'b0011;
      default:          lane_en = 4'b0001 << a;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
    case (op)
      3'd0, 3'd5:       misaligned = (a != 2'b00);
      3'd1, 3'd2, 3'd6: misaligned = a[0];
      default:          misaligned = 1'b0;
    endcase
  endfunction

  assign is_load = (op_q < 3'd5);
  assign timeout = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign byteen  = lane_en(op_q, addr_q[1:0]);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    exc_d      = exc_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    exc_adel   = 1'b0;
    exc_ades   = 1'b0;
    exc_bus    = 1'b0;
    bus_req    = 1'b0;
    bus_we     = 1'b0;
    bus_addr   = '0;
    bus_byteen = '0;
    bus_wdata  = '0;
    ext_byteen = '0;
    ext_op     = 1'b0;
    ext_din    = '0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !flush) begin
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          cnt_d   = '0;
          if (misaligned(req_op, req_addr[1:0])) begin
            exc_d   = (req_op >= 3'd5) ? 3'b010 : 3'b001;
            state_d = S_RESP;
          end else begin
            exc_d   = '0;
            state_d = S_BUS;
          end
        end
      end

      S_BUS, S_DRAIN: begin
        bus_req    = 1'b1;
        bus_we     = !is_load;
        bus_addr   = {addr_q[31:2], 2'b00};
        bus_byteen = byteen;
        if (!is_load) begin
          case (op_q)
            3'd6:    bus_wdata = {2{wdata_q[15:0]}};
            3'd7:    bus_wdata = {4{wdata_q[7:0]}};
            default: bus_wdata = wdata_q;
          endcase
        end
        // A flush (now or earlier, via DRAIN) turns completion into a silent return to IDLE.
        if (bus_ack) begin
          if (is_load) rdata_d = bus_rdata;
          state_d = (state_q == S_BUS && !flush) ? S_RESP : S_IDLE;
        end else if (timeout) begin
          exc_d   = 3'b100;
          state_d = (state_q == S_BUS && !flush) ? S_RESP : S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (state_q == S_BUS && flush) state_d = S_DRAIN;
        end
      end

      S_RESP: begin
        state_d    = S_IDLE;
        resp_valid = !flush;
        {exc_bus, exc_ades, exc_adel} = flush ? 3'b000 : exc_q;
        if (is_load) begin
          ext_byteen = byteen;
          ext_op     = (op_q == 3'd1) || (op_q == 3'd3);
          ext_din    = rdata_q;
        end
        if (!flush && is_load && exc_q == 3'b000) resp_rdata = ext_dout;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      exc_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      exc_q   <= exc_d;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: random loads/stores against a behavioural model,
// plus directed flush, timeout and asynchronous-reset cases.
module tb_mem_access_ctrl;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0, reset = 1'b0, flush = 1'b0, req_valid = 1'b0;
  logic        req_ready, resp_valid, exc_adel, exc_ades, exc_bus;
  logic [2:0]  req_op = '0;
  logic [31:0] req_addr = '0, req_wdata = '0, resp_rdata;
  logic        bus_req, bus_we, bus_ack = 1'b0, ext_op;
  logic [31:0] bus_addr, bus_wdata, bus_rdata = '0, ext_din, ext_dout;
  logic [3:0]  bus_byteen, ext_byteen;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .exc_adel(exc_adel), .exc_ades(exc_ades), .exc_bus(exc_bus),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_byteen(bus_byteen),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .ext_byteen(ext_byteen),
    .ext_op(ext_op), .ext_din(ext_din), .ext_dout(ext_dout)
  );

  // Load-extension unit: lowest enabled lane selects the data, lane count selects the width.
  int unsigned ext_lo, ext_n;
  logic [31:0] ext_v;
  always_comb begin
    ext_lo = 0;
    ext_n  = 0;
    for (int i = 3; i >= 0; i--) if (ext_byteen[i]) begin ext_lo = i; ext_n++; end
    ext_v = ext_din >> (8 * ext_lo);
    case (ext_n)
      1:       ext_dout = ext_op ? {{24{ext_v[7]}}, ext_v[7:0]}   : {24'b0, ext_v[7:0]};
      2:       ext_dout = ext_op ? {{16{ext_v[15]}}, ext_v[15:0]} : {16'b0, ext_v[15:0]};
      default: ext_dout = ext_v;
    endcase
  end

  typedef struct {
    logic [31:0] rdata; logic [2:0] exc; bit is_load; logic [3:0] ben; bit sx; int unsigned cyc;
  } resp_t;
  typedef struct {
    int unsigned d; logic [31:0] r; bit we; logic [31:0] addr; logic [3:0] ben; logic [31:0] wdata;
  } plan_t;

  resp_t exp_q[$];
  plan_t plan_q[$];
  int unsigned n_pass = 0, n_total = 0, cyc = 0;
  bit rst_test = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic void model(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                                input int unsigned d, input logic [31:0] r,
                                output resp_t e, output plan_t p, output bit mis);
    int unsigned size, lane;
    logic [63:0] mask, v;
    bit load;
    size = (op == 0 || op == 5) ? 4 : (op == 1 || op == 2 || op == 6) ? 2 : 1;
    lane = addr % 4;
    load = (op < 5);
    mis  = (lane % size) != 0;
    mask = (64'd1 << (8 * size)) - 1;
    p.d = d; p.r = r; p.we = !load; p.addr = addr - lane;
    p.ben = 4'(((1 << size) - 1) << lane);
    p.wdata = (size == 4) ? wdata : (size == 2) ? (wdata & 32'hFFFF) * 32'h0001_0001
                                               : (wdata & 32'hFF) * 32'h0101_0101;
    e.is_load = load; e.ben = p.ben; e.sx = (op == 1 || op == 3); e.rdata = '0;
    if (mis) begin
      e.exc = load ? 3'b001 : 3'b010; e.cyc = 1;
    end else if (d >= TO) begin
      e.exc = 3'b100; e.cyc = TO + 1;
    end else begin
      e.exc = 3'b000; e.cyc = d + 2;
      if (load) begin
        v = ({32'b0, r} >> (8 * lane)) & mask;
        if (e.sx && v[8 * size - 1]) v = v | ~mask;
        e.rdata = v[31:0];
      end
    end
  endfunction

  // Waits for req_ready, presents one request and returns one cycle after it is accepted.
  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input int unsigned d, input logic [31:0] r, input bit want);
    resp_t e; plan_t p; bit mis;
    int unsigned n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("req_ready_wait", req_ready, 1);
    model(op, addr, wdata, d, r, e, p, mis);
    if (!mis) plan_q.push_back(p);
    e.cyc = e.cyc + cyc;
    if (want) exp_q.push_back(e);
    req_valid = 1; req_op = op; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 0; req_op = $urandom; req_addr = $urandom; req_wdata = $urandom;
  endtask

  task automatic flush_bus(input logic [2:0] op, input logic [31:0] addr, input int unsigned k,
                           input int unsigned d);
    int unsigned e;
    issue(op, addr, $urandom, d, $urandom, 0);
    repeat (k) begin @(posedge clk); #1; end
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    e = (d < TO) ? d + 1 : TO;
    for (int unsigned c = k + 1; c <= e; c++) begin
      chk("flush_drain_ready", req_ready, (c == e));
      if (c < e) begin @(posedge clk); #1; end
    end
  endtask

  // Bus slave: follows a per-transaction plan and checks the held request fields.
  initial begin : responder
    plan_t p; bit active = 0, have = 0; int unsigned i = 0;
    forever begin
      @(posedge clk); #1;
      bus_ack = 0;
      if (bus_req) begin
        if (!active) begin
          active = 1; i = 0; have = plan_q.size() != 0;
          if (have) p = plan_q.pop_front(); else chk("bus_req_unexpected", bus_req, 0);
        end else i++;
        if (have) begin
          chk("bus_addr", bus_addr, p.addr);
          chk("bus_we", bus_we, p.we);
          chk("bus_byteen", bus_byteen, p.ben);
          if (p.we) chk("bus_wdata", bus_wdata, p.wdata);
          if (i == p.d) begin bus_ack = 1; bus_rdata = p.r; end
          else bus_rdata = $urandom;
        end
      end else begin
        if (active && have && !rst_test) chk("bus_req_cycles", i + 1, (p.d < TO) ? p.d + 1 : TO);
        active = 0;
      end
    end
  end

  resp_t mon_e;
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (reset) begin
        if (resp_valid) begin
          if (exp_q.size() == 0) chk("resp_unexpected", resp_valid, 0);
          else begin
            mon_e = exp_q.pop_front();
            chk("resp_cycle", cyc, mon_e.cyc);
            chk("resp_rdata", resp_rdata, mon_e.rdata);
            chk("resp_exc", {exc_bus, exc_ades, exc_adel}, mon_e.exc);
            if (mon_e.is_load && mon_e.exc == 3'b000) begin
              chk("ext_byteen", ext_byteen, mon_e.ben);
              chk("ext_op", ext_op, mon_e.sx);
            end
          end
        end else chk("exc_without_resp", {exc_bus, exc_ades, exc_adel}, 0);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [2:0] op; logic [31:0] a; int unsigned n;
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp", {resp_valid, exc_adel, exc_ades, exc_bus, bus_req, bus_we}, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_byteen", bus_byteen, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_ext", {ext_byteen, ext_op}, 0);
    chk("rst_ext_din", ext_din, 0);
    reset = 1;
    @(posedge clk); #1;

    issue(0, 32'h10, $urandom, 3, 32'hDEAD_BEEF, 1);
    issue(3, 32'h13, $urandom, 1, 32'h8011_2233, 1);
    issue(4, 32'h13, $urandom, 0, 32'h8011_2233, 1);
    issue(6, 32'h22, 32'h0000_ABCD, 2, $urandom, 1);
    issue(0, 32'h12, $urandom, 0, $urandom, 1);
    issue(6, 32'h21, $urandom, 0, $urandom, 1);
    issue(1, 32'h42, $urandom, TO - 1, 32'h8123_4567, 1);
    issue(2, 32'h40, $urandom, 2, 32'h0000_F00D, 1);
    issue(7, 32'h7, 32'h1234_56A5, 0, $urandom, 1);
    issue(0, 32'h80, $urandom, 99, $urandom, 1);
    issue(5, 32'h84, 32'hCAFE_F00D, TO, $urandom, 1);

    for (int t = 0; t < 150; t++) begin
      op = $urandom; a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (op == 0 || op == 5) a[1:0] = 2'b00;
        else if (op == 1 || op == 2 || op == 6) a[0] = 1'b0;
      end
      issue(op, a, $urandom, $urandom_range(0, TO + 1), $urandom, 1);
    end

    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    req_valid = 1; req_op = 0; req_addr = 32'h100; flush = 1;
    @(posedge clk); #1;
    req_valid = 0; flush = 0;
    chk("flush_idle_ready", req_ready, 1);
    chk("flush_idle_bus_req", bus_req, 0);

    flush_bus(0, 32'h10, 1, 3);
    flush_bus(7, 32'h23, 2, 2);
    flush_bus(5, 32'h30, 0, 99);
    flush_bus(1, 32'h32, TO - 1, TO - 1);

    issue(0, 32'h12, $urandom, 0, $urandom, 0);
    flush = 1;
    #1 chk("flush_resp_valid", resp_valid, 0);
    @(posedge clk); #1;
    flush = 0;
    chk("flush_resp_ready", req_ready, 1);

    issue(0, 32'h40, $urandom, 99, $urandom, 0);
    rst_test = 1;
    @(posedge clk); #1;
    chk("pre_reset_bus_req", bus_req, 1);
    #2 reset = 0;
    #1 chk("async_reset_bus_req", bus_req, 0);
    chk("async_reset_ready", req_ready, 1);
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    rst_test = 0;
    issue(3, 32'h11, $urandom, 1, 32'h0000_7F00, 1);

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    repeat (3) begin @(posedge clk); #1; end
    chk("pending_responses", exp_q.size(), 0);
    chk("pending_bus_plans", plan_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
